// File: rtl/seg7_digit_scanner_if.sv
// seg7_digit_scanner_if: display bus; controller drives value/blank/lz_suppress, scanner drives an/digit/digit_sel/frame_done
interface seg7_digit_scanner_if;
  logic [15:0] value;
  logic [3:0] blank;
  logic lz_suppress;
  logic [3:0] an;
  logic [3:0] digit;
  logic [1:0] digit_sel;
  logic frame_done;
  modport master (output value, blank, lz_suppress, input an, digit, digit_sel, frame_done);
  modport slave (input value, blank, lz_suppress, output an, digit, digit_sel, frame_done);
endinterface

// File: rtl/seg7_digit_scanner.sv
// seg7_digit_scanner: 4-digit 7-seg scanner with frame shadow, blanking, leading-zero suppression and dead-time; ports clk, reset, bus(value/blank/lz_suppress in, an/digit/digit_sel/frame_done out)
module seg7_digit_scanner #(
  parameter int DIVIDE_BY = 17,
  parameter int DEAD_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  seg7_digit_scanner_if.slave bus
);
  logic [DIVIDE_BY-1:0] cnt;
  logic [1:0] idx;
  logic [15:0] sv;
  logic [3:0] sb;
  logic sl;
  logic fd;
  logic last;
  logic frame;
  logic [3:0] z;
  logic [3:0] sup;
  logic dark;
  always_comb begin
    last = &cnt;
    frame = last && (idx == 2'd3);
    z = {sv[15:12] == 4'd0, sv[11:8] == 4'd0, sv[7:4] == 4'd0, sv[3:0] == 4'd0};
    sup = sl ? {z[3], &z[3:2], &z[3:1], 1'b0} : 4'b0000;
    dark = reset || (cnt < DIVIDE_BY'(DEAD_CYCLES)) || sb[idx] || sup[idx];
    bus.an = dark ? 4'b1111 : ~(4'b0001 << idx);
    bus.digit = sv[{idx, 2'b00} +: 4];
    bus.digit_sel = idx;
    bus.frame_done = fd;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= 2'd0;
      fd <= 1'b0;
      sv <= bus.value;
      sb <= bus.blank;
      sl <= bus.lz_suppress;
    end else begin
      cnt <= cnt + 1'b1;
      idx <= last ? idx + 2'd1 : idx;
      fd <= frame;
      if (frame) begin
        sv <= bus.value;
        sb <= bus.blank;
        sl <= bus.lz_suppress;
      end
    end
  end
endmodule

// File: tb/tb_seg7_digit_scanner.sv
// tb_seg7_digit_scanner: directed and random scoreboard bench for seg7_digit_scanner with P=4, one dead cycle
module tb_seg7_digit_scanner;
  typedef struct {
    logic [3:0] an;
    logic [3:0] dg;
    logic [1:0] ds;
    logic fd;
    logic ca;
    logic cd;
    string tag;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  seg7_digit_scanner_if bus ();
  seg7_digit_scanner #(.DIVIDE_BY(2), .DEAD_CYCLES(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic cyc(input logic [3:0] a, input logic [3:0] d, input logic [1:0] s, input logic f, input logic ca, input logic cd, input string tag);
    exp_t e;
    e.an = a;
    e.dg = d;
    e.ds = s;
    e.fd = f;
    e.ca = ca;
    e.cd = cd;
    e.tag = tag;
    q.push_back(e);
    #1;
    e = q.pop_front();
    if (e.ca) begin
      n_cmp++;
      assert (bus.an === e.an) else begin n_bad++; $error("FAIL %s_an got %b want %b", e.tag, bus.an, e.an); end
    end
    if (e.cd) begin
      n_cmp++;
      assert (bus.digit === e.dg) else begin n_bad++; $error("FAIL %s_digit got %h want %h", e.tag, bus.digit, e.dg); end
      n_cmp++;
      assert (bus.digit_sel === e.ds) else begin n_bad++; $error("FAIL %s_sel got %0d want %0d", e.tag, bus.digit_sel, e.ds); end
    end
    n_cmp++;
    assert (bus.frame_done === e.fd) else begin n_bad++; $error("FAIL %s_frame_done got %b want %b", e.tag, bus.frame_done, e.fd); end
    n_cmp++;
    assert ($countones(~bus.an) <= 1) else begin n_bad++; $error("FAIL %s_onehot got %b want at most one low", e.tag, bus.an); end
    @(negedge clk);
  endtask
  task automatic frame(input logic [15:0] v, input logic [3:0] lit, input logic f0, input int len, input int chg_at, input logic [15:0] chg_v, input string tag);
    int i;
    int c;
    logic [3:0] a;
    for (int k = 0; k < len; k++) begin
      i = k / 4;
      c = k % 4;
      if (k == chg_at) bus.value = chg_v;
      a = (c == 0 || !lit[i]) ? 4'b1111 : ~(4'b0001 << i);
      cyc(a, v[i*4 +: 4], 2'(i), (k == 0) ? f0 : 1'b0, 1'b1, 1'b1, tag);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.value = 16'h1234;
    bus.blank = 4'b0000;
    bus.lz_suppress = 1'b0;
    @(negedge clk);
    cyc(4'b1111, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0, "reset");
    cyc(4'b1111, 4'h4, 2'd0, 1'b0, 1'b1, 1'b1, "reset");
    reset = 1'b0;
    frame(16'h1234, 4'b1111, 1'b0, 16, 6, 16'hABCD, "basic");
    bus.lz_suppress = 1'b1;
    bus.value = 16'h0030;
    frame(16'hABCD, 4'b1111, 1'b1, 16, -1, 16'h0, "tearing");
    bus.value = 16'h0000;
    frame(16'h0030, 4'b0011, 1'b1, 16, -1, 16'h0, "lz0030");
    bus.lz_suppress = 1'b0;
    bus.blank = 4'b0101;
    bus.value = 16'h1234;
    frame(16'h0000, 4'b0001, 1'b1, 16, -1, 16'h0, "lz0000");
    bus.blank = 4'b0000;
    bus.value = 16'h5A5A;
    frame(16'h1234, 4'b1010, 1'b1, 16, -1, 16'h0, "blank");
    frame(16'h5A5A, 4'b1111, 1'b1, 10, -1, 16'h0, "prereset");
    reset = 1'b1;
    cyc(4'b1111, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0, "midreset");
    cyc(4'b1111, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0, "midreset");
    reset = 1'b0;
    frame(16'h5A5A, 4'b1111, 1'b0, 16, -1, 16'h0, "restart");
    for (int f = 0; f < 50; f++) begin
      bus.value = 16'($urandom);
      bus.blank = 4'($urandom_range(0, 15));
      bus.lz_suppress = 1'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) begin
        if (k == 7) bus.value = 16'($urandom);
        cyc(4'b0000, 4'h0, 2'd0, k == 0, 1'b0, 1'b0, "random");
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
